// File: rtl/muldiv_wb_unit_if.sv
// muldiv_wb_unit_if
//   Bundles the issue request and the register-file write-back triple of the
//   iterative multiply/divide unit.
//   Request (issuer -> unit): start, op, is_signed, rs_a, rs_b, rd_idx
//   Status / write-back (unit -> issuer, regfile): busy, done, we, wa, wd
//   master: issuing logic side; slave: the execution unit.
interface muldiv_wb_unit_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             start;
    logic [1:0]       op;
    logic             is_signed;
    logic [WIDTH-1:0] rs_a;
    logic [WIDTH-1:0] rs_b;
    logic [AW-1:0]    rd_idx;
    logic             busy;
    logic             done;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;

    modport master (
        output start, op, is_signed, rs_a, rs_b, rd_idx,
        input  busy, done, we, wa, wd
    );

    modport slave (
        input  start, op, is_signed, rs_a, rs_b, rd_idx,
        output busy, done, we, wa, wd
    );
endinterface

// File: rtl/muldiv_wb_unit.sv
// muldiv_wb_unit
//   Shared iterative multiply/divide unit sitting behind the register file
//   read ports. One operation in flight at a time: IDLE -> RUN (WIDTH
//   iterations) -> FIXUP (sign correction, result select) -> WB (one-cycle
//   write-back pulse) -> IDLE.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous active-high reset, clears all state
//     bus    - slave side of muldiv_wb_unit_if:
//              start/op/is_signed/rs_a/rs_b/rd_idx in,
//              busy/done/we/wa/wd out (we/wa/wd feed regfile we3/wa3/wd3)
//   op: 00 MUL low word, 01 MULH high word, 10 DIV quotient, 11 REM remainder
module muldiv_wb_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    muldiv_wb_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, WB} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {product_hi, multiplier/product_lo}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [1:0]         op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [AW-1:0]      rd_idx_q, rd_idx_d;
    logic [AW-1:0]      wa_q, wa_d;
    logic [WIDTH-1:0]   wd_q, wd_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign a_s   = bus.rs_a;
    assign b_s   = bus.rs_b;
    assign a_mag = neg_w(bus.rs_a, bus.is_signed & a_s[WIDTH-1]);
    assign b_mag = neg_w(bus.rs_b, bus.is_signed & b_s[WIDTH-1]);

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole register right by one.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring step: remainder shifted left with the next dividend bit.
    // A zero divisor always "fits", which yields all-ones quotient and the
    // dividend as remainder without special casing the iteration.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    assign prod_fix = neg_dw(acc_q, neg_res_q);
    // Divide by zero keeps the raw all-ones quotient regardless of signs.
    // Signed overflow (MIN / -1) falls out naturally: |MIN| negated is MIN.
    assign quo_fix  = (opnd_q == '0) ? '1 : neg_w(acc_q[WIDTH-1:0], neg_res_q);
    assign rem_fix  = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        rd_idx_d  = rd_idx_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    op_d      = bus.op;
                    rd_idx_d  = bus.rd_idx;
                    neg_res_d = bus.is_signed & (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
                    neg_rem_d = bus.is_signed & a_s[WIDTH-1];
                    if (bus.op[1]) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIXUP;
                    cnt_d   = '0;
                end
            end
            FIXUP: begin
                state_d = WB;
                wa_d    = rd_idx_q;
                case (op_q)
                    2'b00:   wd_d = prod_fix[WIDTH-1:0];
                    2'b01:   wd_d = prod_fix[2*WIDTH-1:WIDTH];
                    2'b10:   wd_d = quo_fix;
                    default: wd_d = rem_fix;
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_idx_q  <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            rd_idx_q  <= rd_idx_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    // Register index 0 is hard-wired zero, so its write is dropped while
    // completion is still signalled.
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == WB);
    assign bus.we   = (state_q == WB) && (wa_q != '0);
    assign bus.wa   = wa_q;
    assign bus.wd   = wd_q;
endmodule

// File: tb/tb_muldiv_wb_unit.sv
module tb_muldiv_wb_unit;
    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muldiv_wb_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    muldiv_wb_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  idx;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issues one operation and checks busy, completion latency, write-back
    // triple and post-WB state. glitch > 0 pulses a second start with other
    // operands that many edges after acceptance.
    task automatic run_op(input string name, input logic [1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] idx, input logic [31:0] exp,
                          input int glitch);
        int n;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.is_signed = sgn;
        bus.rs_a      = a;
        bus.rs_b      = b;
        bus.rd_idx    = idx;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.rs_a   = 32'hDEAD_BEEF;
        bus.rs_b   = 32'h1234_5678;
        bus.rd_idx = 5'd17;
        bus.op     = ~op;
        check({name, ".busy_rise"}, {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (glitch > 0 && n == glitch) begin
                bus.start     = 1'b1;
                bus.is_signed = ~sgn;
                bus.rs_a      = 32'h0000_0003;
                bus.rs_b      = 32'h0000_0009;
            end else if (glitch > 0 && n == glitch + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
        end
        check({name, ".latency"}, n, 32'd33);
        check({name, ".we"}, {31'd0, bus.we}, {31'd0, (idx != 5'd0)});
        check({name, ".wa"}, {27'd0, bus.wa}, {27'd0, idx});
        check({name, ".wd"}, bus.wd, exp);
        @(posedge clk);
        #1;
        check({name, ".busy_fall"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({name, ".wd_hold"}, bus.wd, exp);
    endtask

    initial begin
        logic saw_done;
        checks = 0;
        errors = 0;

        vecs[0]  = '{2'b00, 1'b0, 32'd7,         32'd6,         5'd5,  32'h0000_002A};
        vecs[1]  = '{2'b01, 1'b1, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF};
        vecs[2]  = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'h0000_0001};
        vecs[3]  = '{2'b00, 1'b1, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFE};
        vecs[4]  = '{2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFE};
        vecs[5]  = '{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD};
        vecs[6]  = '{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF};
        vecs[7]  = '{2'b10, 1'b0, 32'h2B97_1485, 32'h0000_0010, 5'd31, 32'h02B9_7148};
        vecs[8]  = '{2'b11, 1'b0, 32'h2B97_1485, 32'h0000_0010, 5'd31, 32'h0000_0005};
        vecs[9]  = '{2'b10, 1'b0, 32'd100,       32'd0,         5'd7,  32'hFFFF_FFFF};
        vecs[10] = '{2'b11, 1'b0, 32'd100,       32'd0,         5'd7,  32'h0000_0064};
        vecs[11] = '{2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h8000_0000};
        vecs[12] = '{2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
        vecs[13] = '{2'b10, 1'b1, 32'hFFFF_FFF9, 32'd0,         5'd4,  32'hFFFF_FFFF};
        vecs[14] = '{2'b11, 1'b1, 32'hFFFF_FFF9, 32'd0,         5'd4,  32'hFFFF_FFF9};
        vecs[15] = '{2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000};
        vecs[16] = '{2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5,         5'd10, 32'hFFFF_FFF1};
        vecs[17] = '{2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5,         5'd10, 32'hFFFF_FFFF};
        vecs[18] = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE};

        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.is_signed = 1'b0;
        bus.rs_a      = '0;
        bus.rs_b      = '0;
        bus.rd_idx    = '0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy_done_we", {29'd0, bus.busy, bus.done, bus.we}, 32'd0);
        check("reset.wa", {27'd0, bus.wa}, 32'd0);
        check("reset.wd", bus.wd, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a,
                   vecs[i].b, vecs[i].idx, vecs[i].exp, 0);
        end

        // Second start while busy must not disturb the operation in flight.
        run_op("glitch_start", 2'b00, 1'b0, 32'd7, 32'd6, 5'd12, 32'h0000_002A, 10);
        // Destination 0: done pulses, write enable suppressed.
        run_op("rd_zero", 2'b00, 1'b0, 32'd9, 32'd9, 5'd0, 32'h0000_0051, 0);

        // Reset in the middle of a DIV aborts it without write-back.
        bus.start     = 1'b1;
        bus.op        = 2'b10;
        bus.is_signed = 1'b0;
        bus.rs_a      = 32'd1000;
        bus.rs_b      = 32'd7;
        bus.rd_idx    = 5'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort.busy_done_we", {29'd0, bus.busy, bus.done, bus.we}, 32'd0);
        check("abort.wa", {27'd0, bus.wa}, 32'd0);
        check("abort.wd", bus.wd, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("abort.no_done", {31'd0, saw_done}, 32'd0);
        run_op("after_abort", 2'b10, 1'b0, 32'd1000, 32'd7, 5'd6, 32'd142, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_wb_unit.md
Name: muldiv_wb_unit

Overview:
Iterative multi-cycle multiply/divide unit downstream of the register file read ports. It takes rd1/rd2 as operands plus a destination index. It produces a one-cycle write-back triple (we, wa, wd) that drives the register file write port (we3/wa3/wd3). It is a shared sequential execution resource, so the issuing logic must wait on busy.

Parameters:
WIDTH, 32, operand/result width in bits
AW, 5, register index width (32 architectural registers)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
start  input  1  request; accepted only in IDLE
op  input  2  00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder)
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
rs_a  input  WIDTH  operand A / dividend (from regfile rd1)
rs_b  input  WIDTH  operand B / divisor (from regfile rd2)
rd_idx  input  AW  destination register index
busy  output  1  high from the accepting edge until return to IDLE
done  output  1  one-cycle completion pulse
we  output  1  regfile write enable (to we3)
wa  output  AW  write address (to wa3)
wd  output  WIDTH  write data (to wd3)

Behaviour:
- Reset values: busy=0, done=0, we=0, wa=0, wd=0, state=IDLE, counter=0, internal accumulators=0.
- FSM states: IDLE, RUN, FIXUP, WB.
- IDLE: on an edge with start=1, latch op, is_signed, rd_idx, and the operand magnitudes (absolute values when is_signed=1). Latch the result-sign and remainder-sign flags. Go to RUN with counter=0 and busy=1. Operand inputs may change freely after this edge.
- RUN: one iteration per cycle, exactly WIDTH cycles. Leave RUN on the edge where counter==WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract producing WIDTH-bit quotient and remainder.
- FIXUP (1 cycle):
  - Apply sign correction. Product is negated if sign(A) xor sign(B). Quotient is negated if sign(A) xor sign(B). Remainder takes the sign of the dividend.
  - Select the result by op: MUL = product[WIDTH-1:0], MULH = product[2*WIDTH-1:WIDTH].
  - Load wd and wa.
- WB (1 cycle): done=1. we=1 only if wa!=0; writes to index 0 are suppressed, but done still pulses. Next edge goes to IDLE and busy=0.
- Latency: start accepted at edge E0. done/we are high during the cycle between E0+WIDTH+1 and E0+WIDTH+2 (E33–E34 at WIDTH=32). A new start is accepted no earlier than edge E0+WIDTH+2.
- start while busy=1 is ignored; the operation in flight is unaffected.
- wd and wa hold their last values after WB; we and done are low outside WB.
- Divide by zero: quotient = all ones; remainder = dividend (original, unsigned-converted value). No trap. Full latency still applies.
- Signed overflow (DIV/REM, signed, A = most negative, B = -1): quotient = most-negative value (0x80000000), remainder = 0.
- MULH with is_signed=0: full unsigned high word. With is_signed=1: signed×signed high word.
- Reset mid-operation: on the reset edge, return to IDLE with all outputs cleared. No write-back is produced for the aborted operation. Reset has priority over start on the same edge.
- All arithmetic is modulo 2^WIDTH except the internal 2*WIDTH product; no X propagation from unused accumulator bits.

Test Plan:
1. MUL, unsigned, rs_a=7, rs_b=6, rd_idx=5 -> busy rises after start edge; done=1, we=1, wa=5, wd=0x0000002A exactly 33 edges after start; busy=0 after edge 34.
2. MULH, rs_a=0xFFFFFFFF, rs_b=2, rd_idx=3 -> signed: wd=0xFFFFFFFF. Unsigned: wd=0x00000001. MUL low word: wd=0xFFFFFFFE in both modes.
3. DIV/REM, signed, rs_a=0xFFFFFFF9 (-7), rs_b=2 -> DIV wd=0xFFFFFFFD (-3); REM wd=0xFFFFFFFF (-1). Unsigned DIV of 0x2B971485/0x10 -> wd=0x02B97148.
4. Corner divides -> 100/0: DIV wd=0xFFFFFFFF, REM wd=0x00000064. Signed 0x80000000/0xFFFFFFFF: DIV wd=0x80000000, REM wd=0x00000000.
5. Second start pulsed at cycle 10 with different operands -> ignored; the first result is still correct. Operation with rd_idx=0 -> done=1, we=0.
6. reset asserted at cycle 12 of a DIV -> next cycle busy=0, done=0, we=0, wa=0, wd=0. No done pulse follows. A fresh start then completes normally.
